// File: rtl/ldpc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_pkg : shared LLR types, decoder FSM states and symmetric saturation |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ldpc_pkg;

  localparam int LLR_WIDTH   = 8;
  localparam int LLR_MAX_DEG = 6;
  localparam int LLR_SUM_W   = LLR_WIDTH + $clog2(LLR_MAX_DEG + 2);

  typedef logic signed [LLR_WIDTH-1:0] llr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LOAD  = 2'd2,
    EMIT  = 2'd3
  } vn_state_t;

  // Symmetric clamp: -2^(W-1) is never produced, so downstream negation is safe.
  function automatic llr_t llr_sat(input logic signed [LLR_SUM_W-1:0] x);
    logic signed [LLR_SUM_W-1:0] lim;
    lim = LLR_SUM_W'((2 ** (LLR_WIDTH - 1)) - 1);
    if (x > lim)       llr_sat = llr_t'(lim);
    else if (x < -lim) llr_sat = llr_t'(-lim);
    else               llr_sat = llr_t'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_vn_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_vn_buffer : per-edge C2V register file, one write and one read port |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ldpc_vn_buffer
  import ldpc_pkg::*;
#(
  parameter int WIDTH = LLR_WIDTH,
  parameter int DEPTH = LLR_MAX_DEG,
  parameter int IDX_W = $clog2(LLR_MAX_DEG + 1)
) (
  input  logic             i_clock,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data is overwritten every frame before it is read, so no reset is needed.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [WIDTH-1:0] entry_q;
    logic [WIDTH-1:0] entry_d;

    always_comb begin
      entry_d = entry_q;
      if (i_wr_en && (i_wr_idx == IDX_W'(g))) entry_d = i_wr_data;
    end

    always_ff @(posedge i_clock) entry_q <= entry_d;

    assign mem[g] = entry_q;
  end

  assign o_rd_data = (i_rd_idx < IDX_W'(DEPTH)) ? mem[i_rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/ldpc_varnode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_varnode : min-sum variable-node update, serial C2V in / V2C out      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ldpc_varnode
  import ldpc_pkg::*;
#(
  parameter int WIDTH   = LLR_WIDTH,
  parameter int MAX_DEG = LLR_MAX_DEG
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_chan,
  input  logic [WIDTH-1:0] i_c2v,
  input  logic             i_valid,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_v2c,
  output logic             o_hard,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_error
);

  localparam int SUM_W = WIDTH + $clog2(MAX_DEG + 2);
  localparam int CNT_W = $clog2(MAX_DEG + 1);

  function automatic logic signed [SUM_W-1:0] sext(input logic [WIDTH-1:0] x);
    sext = {{(SUM_W - WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] lim;
    lim = SUM_W'((2 ** (WIDTH - 1)) - 1);
    if (x > lim)       sat = lim[WIDTH-1:0];
    else if (x < -lim) sat = WIDTH'(-lim);
    else               sat = x[WIDTH-1:0];
  endfunction

  vn_state_t               state_q, state_d;
  logic signed [SUM_W-1:0] total_q, total_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        v2c_q, v2c_d;
  logic                    hard_q, hard_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    buf_we;
  logic [CNT_W-1:0]        buf_widx;
  logic [CNT_W-1:0]        buf_ridx;
  logic [WIDTH-1:0]        buf_rdata;

  ldpc_vn_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEG),
    .IDX_W (CNT_W)
  ) u_buffer (
    .i_clock   (i_clock),
    .i_wr_en   (buf_we),
    .i_wr_idx  (buf_widx),
    .i_wr_data (i_c2v),
    .i_rd_idx  (buf_ridx),
    .o_rd_data (buf_rdata)
  );

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && i_first) state_d = i_last ? LOAD : ACCUM;
      ACCUM: if (accept) begin
        if (i_first)                        state_d = i_last ? LOAD : ACCUM;
        else if (cnt_q == CNT_W'(MAX_DEG))  state_d = IDLE;
        else if (i_last)                    state_d = LOAD;
      end
      LOAD:  state_d = EMIT;
      EMIT:  if (valid_q && i_ready && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE) || (state_q == ACCUM);
  end

  always_comb begin
    total_d  = total_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    v2c_d    = v2c_q;
    hard_d   = hard_q;
    valid_d  = valid_q;
    last_d   = last_q;
    error_d  = 1'b0;
    buf_we   = 1'b0;
    buf_widx = cnt_q;
    buf_ridx = idx_q + CNT_W'(1);
    case (state_q)
      IDLE, ACCUM: if (accept) begin
        if (i_first) begin
          // A first beat mid-frame abandons the partial frame and restarts here.
          error_d  = (state_q == ACCUM);
          total_d  = sext(i_chan) + sext(i_c2v);
          cnt_d    = CNT_W'(1);
          buf_we   = 1'b1;
          buf_widx = '0;
        end else if (state_q == IDLE) begin
          error_d = 1'b1;
        end else if (cnt_q == CNT_W'(MAX_DEG)) begin
          error_d = 1'b1;
          cnt_d   = '0;
        end else begin
          total_d = total_q + sext(i_c2v);
          cnt_d   = cnt_q + CNT_W'(1);
          buf_we  = 1'b1;
        end
      end
      LOAD: begin
        buf_ridx = '0;
        v2c_d    = sat(total_q - sext(buf_rdata));
        hard_d   = total_q[SUM_W-1];
        valid_d  = 1'b1;
        last_d   = (cnt_q == CNT_W'(1));
        idx_d    = '0;
      end
      EMIT: if (valid_q && i_ready) begin
        if (last_q) begin
          valid_d = 1'b0;
        end else begin
          v2c_d  = sat(total_q - sext(buf_rdata));
          last_d = ((idx_q + CNT_W'(2)) == cnt_q);
          idx_d  = idx_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      total_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      v2c_q   <= '0;
      hard_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      total_q <= total_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      v2c_q   <= v2c_d;
      hard_q  <= hard_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  assign o_v2c   = v2c_q;
  assign o_hard  = hard_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_varnode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ldpc_varnode : directed frames, queued expectations, output monitor   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ldpc_varnode;

  typedef struct packed {
    logic signed [7:0] v2c;
    logic              last;
    logic              hard;
  } exp_t;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_chan  = '0;
  logic [7:0] i_c2v   = '0;
  logic       i_valid = 1'b0;
  logic       i_first = 1'b0;
  logic       i_last  = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic [7:0] o_v2c;
  logic       o_hard;
  logic       o_valid;
  logic       o_last;
  logic       o_error;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  ldpc_varnode #(.WIDTH(8), .MAX_DEG(6)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_chan  (i_chan),
    .i_c2v   (i_c2v),
    .i_valid (i_valid),
    .i_first (i_first),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_v2c   (o_v2c),
    .o_hard  (o_hard),
    .o_valid (o_valid),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_error (o_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int v2c, input logic last, input logic hard);
    exp_t e;
    e.v2c  = 8'(v2c);
    e.last = last;
    e.hard = hard;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Holds the beat until o_ready is seen ahead of a rising edge; returns just after that edge.
  task automatic drive_beat(input int chan, input int c2v, input logic first, input logic last);
    logic acc;
    i_chan  = 8'(chan);
    i_c2v   = 8'(c2v);
    i_first = first;
    i_last  = last;
    i_valid = 1'b1;
    acc     = 1'b0;
    for (int k = 0; k < 32 && !acc; k++) begin
      @(negedge i_clock);
      acc = o_ready;
      tick();
    end
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept_timeout chan=%0d c2v=%0d", chan, c2v);
    end
  endtask

  task automatic frame_t1();
    drive_beat(10, 5, 1'b1, 1'b0);
    drive_beat(0, -3, 1'b0, 1'b0);
    drive_beat(0, 7, 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) @(posedge i_clock);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: a handshake is visible at the falling edge before the rising edge that takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (!i_reset && o_valid && i_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output got v2c=%0d last=%0b hard=%0b",
                   $signed(o_v2c), o_last, o_hard);
        end else begin
          e = exp_q.pop_front();
          if ({o_v2c, o_last, o_hard} !== {e.v2c, e.last, e.hard}) begin
            n_err++;
            $display("FAIL v2c_beat got v2c=%0d last=%0b hard=%0b want v2c=%0d last=%0b hard=%0b",
                     $signed(o_v2c), o_last, o_hard, e.v2c, e.last, e.hard);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    // Reset values, and a beat presented during reset must leave no trace.
    repeat (2) tick();
    check("rst_valid", o_valid, 0);
    check("rst_v2c", $signed(o_v2c), 0);
    check("rst_hard", o_hard, 0);
    check("rst_last", o_last, 0);
    check("rst_error", o_error, 0);
    check("rst_ready", o_ready, 1);
    drive_beat(-5, 40, 1'b1, 1'b1);
    i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_beat_ignored", o_valid, 0);
    end

    // Test 1: total 19.
    push_exp(14, 1'b0, 1'b0);
    push_exp(22, 1'b0, 1'b0);
    push_exp(12, 1'b1, 1'b0);
    frame_t1();
    drain("t1_drain");

    // Test 2: saturation in both directions.
    push_exp(127, 1'b0, 1'b0);
    push_exp(127, 1'b1, 1'b0);
    drive_beat(100, 100, 1'b1, 1'b0);
    drive_beat(0, 100, 1'b0, 1'b1);
    drain("t2_pos_drain");
    push_exp(-127, 1'b0, 1'b1);
    push_exp(-127, 1'b1, 1'b1);
    drive_beat(-100, -100, 1'b1, 1'b0);
    drive_beat(0, -100, 1'b0, 1'b1);
    drain("t2_neg_drain");

    // Test 3: back-pressure on the second output beat.
    push_exp(14, 1'b0, 1'b0);
    push_exp(22, 1'b0, 1'b0);
    push_exp(12, 1'b1, 1'b0);
    frame_t1();
    check("t3_ready_load", o_ready, 0);
    tick();
    check("t3_ready_emit", o_ready, 0);
    check("t3_first_valid", o_valid, 1);
    tick();
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_v2c", $signed(o_v2c), 22);
      check("t3_hold_valid", o_valid, 1);
      check("t3_hold_last", o_last, 0);
      check("t3_hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    drain("t3_drain");

    // Test 4: degree-1 frame and output latency.
    push_exp(-5, 1'b1, 1'b0);
    drive_beat(-5, 40, 1'b1, 1'b1);
    check("t4_valid_load", o_valid, 0);
    tick();
    check("t4_valid_rise", o_valid, 1);
    drain("t4_drain");

    // Test 5a: stray beat in IDLE.
    drive_beat(3, 3, 1'b0, 1'b0);
    check("t5a_error", o_error, 1);
    tick();
    check("t5a_error_pulse", o_error, 0);
    check("t5a_no_output", o_valid, 0);

    // Test 5b: seven beats without a last.
    drive_beat(0, 1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive_beat(0, 1, 1'b0, 1'b0);
    check("t5b_no_error_at_6", o_error, 0);
    drive_beat(0, 1, 1'b0, 1'b0);
    check("t5b_error_at_7", o_error, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5b_no_output", o_valid, 0);
    end
    check("t5b_ready_idle", o_ready, 1);

    // Test 5c: restart on a mid-frame first beat.
    push_exp(14, 1'b0, 1'b0);
    push_exp(22, 1'b0, 1'b0);
    push_exp(12, 1'b1, 1'b0);
    drive_beat(1, 2, 1'b1, 1'b0);
    drive_beat(0, 3, 1'b0, 1'b0);
    drive_beat(10, 5, 1'b1, 1'b0);
    check("t5c_error", o_error, 1);
    drive_beat(0, -3, 1'b0, 1'b0);
    check("t5c_error_pulse", o_error, 0);
    drive_beat(0, 7, 1'b0, 1'b1);
    drain("t5c_drain");

    // Test 6: reset while the frame is being emitted.
    i_ready = 1'b0;
    frame_t1();
    tick();
    check("t6_in_emit", o_valid, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("t6_valid_cleared", o_valid, 0);
    check("t6_v2c_cleared", $signed(o_v2c), 0);
    check("t6_last_cleared", o_last, 0);
    check("t6_ready_idle", o_ready, 1);
    i_ready = 1'b1;
    push_exp(14, 1'b0, 1'b0);
    push_exp(22, 1'b0, 1'b0);
    push_exp(12, 1'b1, 1'b0);
    frame_t1();
    drain("t6_drain");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
